// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and read-engine state encoding.
// Commands are {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAct,
        StRd,
        StPre
    } rd_state_e;

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: delays each RD by CAS latency and strobes the FIFO for one burst.
// rd_issue is high the cycle before RD appears on the command bus.
module sdram_rd_capture #(
    parameter int unsigned DQ_W      = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CAS_LAT   = 3
) (
    input  logic            sclk,
    input  logic            reset,
    input  logic            rd_issue,
    input  logic [DQ_W-1:0] sdram_rd_data,
    output logic            rfifo_wr_en,
    output logic [DQ_W-1:0] rfifo_wr_data
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);

    // rd_pipe[k] is high when RD was on the bus k cycles ago
    logic [CAS_LAT:0]  rd_pipe;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_vld;

    assign beat_vld = rd_pipe[CAS_LAT] || (beat_cnt != '0);

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            rd_pipe       <= '0;
            beat_cnt      <= '0;
            rfifo_wr_en   <= 1'b0;
            rfifo_wr_data <= '0;
        end else begin
            rd_pipe <= {rd_pipe[CAS_LAT-1:0], rd_issue};
            if (rd_pipe[CAS_LAT]) begin
                beat_cnt <= BEAT_W'(BURST_LEN - 1);
            end else if (beat_cnt != '0) begin
                beat_cnt <= beat_cnt - BEAT_W'(1);
            end
            rfifo_wr_en   <= beat_vld;
            rfifo_wr_data <= sdram_rd_data;
        end
    end

endmodule

// File: rtl/sdram_rd_engine.sv
// SDRAM read master: multi-burst reads that cross row/bank boundaries, yielding the bus
// for refresh or FIFO backpressure and resuming at the saved address.
module sdram_rd_engine
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_W     = 12,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned DQ_W      = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CAS_LAT   = 3,
    parameter int unsigned T_RCD     = 3,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                            sclk,
    input  logic                            reset,
    input  logic                            rd_trig,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   start_addr,
    input  logic [LEN_W-1:0]                rd_len,
    output logic                            busy,
    output logic                            rd_done,
    output logic                            rd_req,
    input  logic                            rd_en,
    input  logic                            ref_req,
    output logic                            flag_rd_end,
    output logic [3:0]                      rd_cmd,
    output logic [ROW_W-1:0]                rd_addr,
    output logic [BANK_W-1:0]               bank_addr,
    input  logic [DQ_W-1:0]                 sdram_rd_data,
    output logic                            rfifo_wr_en,
    output logic [DQ_W-1:0]                 rfifo_wr_data,
    input  logic                            rfifo_afull
);

    localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int unsigned CNT_W  = 8;

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // {bank,row,col} as one counter so column/row/bank carries happen naturally
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;

    logic [3:0]        cmd_d;
    logic [ROW_W-1:0]  rd_addr_d;
    logic [BANK_W-1:0] bank_addr_d;
    logic              rd_req_d, busy_d, rd_done_d, flag_rd_end_d;
    logic              issue_rd;

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [BANK_W-1:0] bank_q;

    assign col_q  = addr_q[COL_W-1:0];
    assign row_q  = addr_q[COL_W +: ROW_W];
    assign bank_q = addr_q[COL_W+ROW_W +: BANK_W];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        addr_d        = addr_q;
        remain_d      = remain_q;
        cmd_d         = CMD_NOP;
        rd_addr_d     = '0;
        bank_addr_d   = '0;
        busy_d        = busy;
        rd_done_d     = 1'b0;
        flag_rd_end_d = 1'b0;
        issue_rd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rd_trig) begin
                    state_d  = StReq;
                    addr_d   = start_addr;
                    remain_d = (rd_len == '0) ? LEN_W'(1) : rd_len;
                    busy_d   = 1'b1;
                end
            end
            StReq: begin
                cnt_d = '0;
                if (rd_en) begin
                    state_d     = StAct;
                    cmd_d       = CMD_ACT;
                    rd_addr_d   = row_q;
                    bank_addr_d = bank_q;
                end
            end
            StAct: begin
                if (cnt_q == CNT_W'(T_RCD - 1)) begin
                    state_d  = StRd;
                    cnt_d    = '0;
                    issue_rd = 1'b1;
                end
            end
            StRd: begin
                // Burst boundary: col_q already points past the last RD, so 0 means wrap
                if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                    cnt_d = '0;
                    if (remain_q == '0 || col_q == '0 || ref_req || rfifo_afull) begin
                        state_d       = StPre;
                        cmd_d         = CMD_PRE;
                        rd_addr_d[10] = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end
            end
            StPre: begin
                if (cnt_q == CNT_W'(T_RP - 1)) begin
                    cnt_d = '0;
                    if (remain_q == '0) begin
                        state_d       = StIdle;
                        busy_d        = 1'b0;
                        rd_done_d     = 1'b1;
                        flag_rd_end_d = 1'b1;
                    end else if (ref_req || rfifo_afull) begin
                        state_d       = StReq;
                        flag_rd_end_d = 1'b1;
                    end else begin
                        state_d     = StAct;
                        cmd_d       = CMD_ACT;
                        rd_addr_d   = row_q;
                        bank_addr_d = bank_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue_rd) begin
            cmd_d       = CMD_RD;
            rd_addr_d   = ROW_W'(col_q);
            bank_addr_d = bank_q;
            addr_d      = addr_q + ADDR_W'(BURST_LEN);
            remain_d    = remain_q - LEN_W'(1);
        end

        rd_req_d = (state_d == StReq);
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            rd_cmd      <= CMD_NOP;
            rd_addr     <= '0;
            bank_addr   <= '0;
            rd_req      <= 1'b0;
            busy        <= 1'b0;
            rd_done     <= 1'b0;
            flag_rd_end <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            rd_cmd      <= cmd_d;
            rd_addr     <= rd_addr_d;
            bank_addr   <= bank_addr_d;
            rd_req      <= rd_req_d;
            busy        <= busy_d;
            rd_done     <= rd_done_d;
            flag_rd_end <= flag_rd_end_d;
        end
    end

    sdram_rd_capture #(
        .DQ_W      (DQ_W),
        .BURST_LEN (BURST_LEN),
        .CAS_LAT   (CAS_LAT)
    ) u_capture (
        .sclk          (sclk),
        .reset         (reset),
        .rd_issue      (cmd_d == CMD_RD),
        .sdram_rd_data (sdram_rd_data),
        .rfifo_wr_en   (rfifo_wr_en),
        .rfifo_wr_data (rfifo_wr_data)
    );

endmodule
